lfm_sample_framer: RTL and testbench

- Downstream stage of the LFM chirp generator. Consumes the generator's 16-bit offset-binary samples while its busy flag is high, and its one-cycle done pulse.
- Optionally converts samples to two's complement and buffers them in a FIFO.
- Presents them as a valid/ready stream with tlast on the final sample of each chirp.
- Keeps overflow and frame-count status for the control/host side.

---
 rtl/lfm_sample_framer.sv | 132 +++++++++++++
 tb/tb_lfm_sample_framer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfm_sample_framer.sv
// Frames the LFM generator's sample stream into a valid/ready stream with tlast.
// A one-entry hold register delays each sample so tlast lands on the final word of a chirp.
module lfm_sample_framer #(
  parameter int OUT_WIDTH      = 16,
  parameter int ADDR_W         = 6,
  parameter bit CONVERT_SIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OUT_WIDTH-1:0] in_data,
  input  logic                 in_busy,
  input  logic                 in_done,
  input  logic                 clr_ovf,
  output logic [OUT_WIDTH-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic [ADDR_W:0]      level,
  output logic                 overflow,
  output logic [15:0]          frame_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FLUSH} state_t;

  state_t                state_q, state_d;
  logic                  capture, push, push_last, frame_inc;
  logic [OUT_WIDTH-1:0]  conv_data, hold_q;
  logic                  wr_v_q;
  logic [OUT_WIDTH:0]    wr_w_q;
  logic [OUT_WIDTH:0]    mem_q [DEPTH];
  logic [ADDR_W:0]       wr_ptr_q, rd_ptr_q;
  logic                  ovf_q;
  logic [15:0]           frame_q;
  logic                  full, rd_en, wr_en, drop;

  assign conv_data = CONVERT_SIGNED ? (in_data ^ {1'b1, {(OUT_WIDTH-1){1'b0}}}) : in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_busy) state_d = S_HOLD;
      S_HOLD: begin
        if (in_busy && in_done)  state_d = S_FLUSH;
        else if (in_done)        state_d = S_IDLE;
      end
      S_FLUSH: state_d = in_busy ? S_HOLD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    capture   = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    frame_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        capture   = in_busy;
        frame_inc = in_done && !in_busy;
      end
      S_HOLD: begin
        if (in_busy) begin
          push    = 1'b1;
          capture = 1'b1;
        end else if (in_done) begin
          push      = 1'b1;
          push_last = 1'b1;
          frame_inc = 1'b1;
        end
      end
      S_FLUSH: begin
        push      = 1'b1;
        push_last = 1'b1;
        frame_inc = 1'b1;
        capture   = in_busy;
      end
      default: ;
    endcase
  end

  // Pushes are staged one cycle before entering the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q  <= '0;
      wr_v_q  <= 1'b0;
      wr_w_q  <= '0;
      frame_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (capture) hold_q <= conv_data;
      wr_v_q <= push;
      wr_w_q <= {push_last, hold_q};
      if (frame_inc) frame_q <= frame_q + 16'd1;
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (level == (ADDR_W+1)'(DEPTH));
  assign m_tvalid = (level != '0);
  assign rd_en    = m_tvalid && m_tready;
  assign wr_en    = wr_v_q && (!full || rd_en);
  assign drop     = wr_v_q && full && !rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_w_q;
  end

  assign m_tdata   = mem_q[rd_ptr_q[ADDR_W-1:0]][OUT_WIDTH-1:0];
  assign m_tlast   = mem_q[rd_ptr_q[ADDR_W-1:0]][OUT_WIDTH];
  assign overflow  = ovf_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_lfm_sample_framer.sv
// Bench for lfm_sample_framer: directed chirps plus a paced random chirp,
// every cycle compared against a queue-based reference of the framing rules.
module tb_lfm_sample_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_busy = 1'b0;
  logic        in_done = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        m_tready = 1'b0;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic [6:0]  level;
  logic        overflow;
  logic [15:0] frame_cnt;

  lfm_sample_framer #(.OUT_WIDTH(16), .ADDR_W(6), .CONVERT_SIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_busy(in_busy), .in_done(in_done),
    .clr_ovf(clr_ovf), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .level(level), .overflow(overflow), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference: FIFO contents, pending staged word, held sample, deferred end-of-chirp
  logic [16:0] mq[$];
  logic [16:0] outq[$];
  bit          st_v;
  logic [16:0] st_w;
  bit          hold_v;
  logic [15:0] hold_d;
  bit          m_flush;
  bit          m_ovf;
  logic [15:0] m_frames;
  int          maxlvl;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    st_v = 0; st_w = '0; hold_v = 0; hold_d = '0; m_flush = 0; m_ovf = 0; m_frames = '0;
  endtask

  function automatic logic [15:0] conv(input logic [15:0] d);
    return d ^ 16'h8000;
  endfunction

  task automatic stage(input logic [15:0] d, input bit last);
    st_v = 1;
    st_w = {last, d};
  endtask

  task automatic compare_outputs();
    check("tvalid", m_tvalid, (mq.size() != 0));
    check("level", level, mq.size());
    check("overflow", overflow, m_ovf);
    check("frame_cnt", frame_cnt, m_frames);
    if (mq.size() != 0) begin
      check("tdata", m_tdata, mq[0][15:0]);
      check("tlast", m_tlast, mq[0][16]);
    end
  endtask

  task automatic cyc(input logic b, input logic d, input logic [15:0] data,
                     input logic rdy, input logic clr);
    bit rd;
    bit set_ovf;
    bit prev_st_v;
    logic [16:0] prev_st_w;
    in_busy = b; in_done = d; in_data = data; m_tready = rdy; clr_ovf = clr;
    rd = (mq.size() != 0) && rdy;
    @(posedge clk);
    #1;
    if (rd) outq.push_back(mq.pop_front());
    prev_st_v = st_v; prev_st_w = st_w; st_v = 0;
    set_ovf = 0;
    if (prev_st_v) begin
      if (mq.size() < 64) mq.push_back(prev_st_w);
      else set_ovf = 1;
    end
    if (set_ovf) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (m_flush) begin
      stage(hold_d, 1);
      m_frames++;
      m_flush = 0;
      hold_v = b;
      if (b) hold_d = conv(data);
    end else if (hold_v) begin
      if (b) begin
        stage(hold_d, 0);
        hold_d = conv(data);
        if (d) m_flush = 1;
      end else if (d) begin
        stage(hold_d, 1);
        hold_v = 0;
        m_frames++;
      end
    end else if (b) begin
      hold_v = 1;
      hold_d = conv(data);
    end else if (d) begin
      m_frames++;
    end
    if (int'(level) > maxlvl) maxlvl = int'(level);
    compare_outputs();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, rdy, 0);
  endtask

  logic [15:0] exp_data[$];
  logic [15:0] samp;
  logic [15:0] f0;
  int lasts;
  int sent;
  int guard;
  logic bb;

  initial begin
    model_reset();
    #12;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame", frame_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // four-sample chirp, ready held high
    outq.delete();
    cyc(1, 0, 16'h0000, 1, 0);
    cyc(1, 0, 16'h8000, 1, 0);
    cyc(1, 0, 16'hFFFF, 1, 0);
    cyc(1, 0, 16'h7FFF, 1, 0);
    cyc(0, 1, 16'h0000, 1, 0);
    check("t1_pre_tdata", m_tdata, 16'h7FFF);
    check("t1_pre_tlast", m_tlast, 0);
    cyc(0, 0, 16'h0000, 1, 0);
    check("t1_lat_tvalid", m_tvalid, 1);
    check("t1_lat_tdata", m_tdata, 16'hFFFF);
    check("t1_lat_tlast", m_tlast, 1);
    idle(3, 1);
    check("t1_count", outq.size(), 4);
    if (outq.size() == 4) begin
      check("t1_w0", outq[0], {1'b0, 16'h8000});
      check("t1_w1", outq[1], {1'b0, 16'h0000});
      check("t1_w2", outq[2], {1'b0, 16'h7FFF});
      check("t1_w3", outq[3], {1'b1, 16'hFFFF});
    end
    check("t1_frames", frame_cnt, 1);

    // 70 samples into a stalled 64-deep FIFO
    outq.delete();
    for (int i = 0; i < 70; i++) cyc(1, 0, 16'(i * 3 + 1), 0, 0);
    cyc(0, 1, 16'h0, 0, 0);
    idle(3, 0);
    check("t2_level_sat", level, 64);
    check("t2_overflow", overflow, 1);
    check("t2_frames", frame_cnt, 2);
    guard = 0;
    while (mq.size() != 0 && guard < 100) begin
      cyc(0, 0, 16'h0, 1, 0);
      guard++;
    end
    idle(2, 1);
    check("t2_drained", level, 0);
    check("t2_count", outq.size(), 64);
    lasts = 0;
    foreach (outq[i]) if (outq[i][16]) lasts++;
    check("t2_no_tlast", lasts, 0);
    check("t2_ovf_sticky", overflow, 1);
    cyc(0, 0, 16'h0, 1, 1);
    check("t2_ovf_clr", overflow, 0);

    // busy and done together on the 3rd sample, then a new chirp right away
    outq.delete();
    cyc(1, 0, 16'h1111, 1, 0);
    cyc(1, 0, 16'h2222, 1, 0);
    cyc(1, 1, 16'h3333, 1, 0);
    cyc(1, 0, 16'h4444, 1, 0);
    cyc(1, 0, 16'h5555, 1, 0);
    cyc(0, 1, 16'h0, 1, 0);
    idle(4, 1);
    check("t3_count", outq.size(), 5);
    if (outq.size() == 5) begin
      check("t3_w0", outq[0], {1'b0, 16'h9111});
      check("t3_w1", outq[1], {1'b0, 16'hA222});
      check("t3_w2", outq[2], {1'b1, 16'hB333});
      check("t3_w3", outq[3], {1'b0, 16'hC444});
      check("t3_w4", outq[4], {1'b1, 16'hD555});
    end
    check("t3_frames", frame_cnt, 4);

    // empty frame
    outq.delete();
    cyc(0, 1, 16'h0, 1, 0);
    idle(3, 1);
    check("t4_tvalid", m_tvalid, 0);
    check("t4_count", outq.size(), 0);
    check("t4_frames", frame_cnt, 5);

    // 1000 paced samples with random ready
    outq.delete();
    exp_data.delete();
    maxlvl = 0;
    sent = 0;
    guard = 0;
    while (sent < 1000 && guard < 20000) begin
      bb = ($urandom_range(0, 2) == 0);
      samp = 16'($urandom);
      cyc(bb, 0, samp, 1'($urandom_range(0, 1)), 0);
      if (bb) begin
        exp_data.push_back(samp ^ 16'h8000);
        sent++;
      end
      guard++;
    end
    cyc(0, 1, 16'h0, 1'($urandom_range(0, 1)), 0);
    guard = 0;
    while ((mq.size() != 0 || st_v || hold_v) && guard < 3000) begin
      cyc(0, 0, 16'h0, 1'($urandom_range(0, 1)), 0);
      guard++;
    end
    idle(2, 1);
    check("t5_count", outq.size(), 1000);
    check("t5_overflow", overflow, 0);
    check("t5_maxlvl_ok", (maxlvl <= 64), 1);
    lasts = 0;
    foreach (outq[i]) if (outq[i][16]) lasts++;
    check("t5_one_tlast", lasts, 1);
    if (outq.size() == 1000 && exp_data.size() == 1000) begin
      for (int i = 0; i < 1000; i++) begin
        check("t5_data", outq[i][15:0], exp_data[i]);
        check("t5_last", outq[i][16], (i == 999));
      end
    end

    // reset in the middle of a stalled chirp
    guard = 0;
    while (mq.size() < 10 && guard < 50) begin
      cyc(1, 0, 16'(guard + 16'h0100), 0, 0);
      guard++;
    end
    check("t6_level10", level, 10);
    rst = 1'b1;
    #1;
    model_reset();
    check("t6_rst_tvalid", m_tvalid, 0);
    check("t6_rst_level", level, 0);
    check("t6_rst_frame", frame_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    outq.delete();
    cyc(1, 0, 16'h0ABC, 1, 0);
    cyc(1, 0, 16'h8DEF, 1, 0);
    cyc(0, 1, 16'h0, 1, 0);
    idle(4, 1);
    check("t6_count", outq.size(), 2);
    if (outq.size() == 2) begin
      check("t6_w0", outq[0], {1'b0, 16'h8ABC});
      check("t6_w1", outq[1], {1'b1, 16'h0DEF});
    end
    check("t6_frames", frame_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
